spi_arbitro_ctrl: RTL and testbench

Transaction controller and two-port round-robin arbiter placed in front of the SPI transmitter. Two requesters each post an SPI mode ({CKP,CPH}) and a byte count. The controller grants one requester at a time, drives the transmitter's CKP/CPH/ENB with guard intervals before and after each transfer, and marks byte boundaries. Completion is signalled per requester with a one-cycle DONE pulse.

---
 rtl/spi_pkg.sv | 45 ++++
 rtl/rr_arb2.sv | 44 ++++
 rtl/spi_arbitro_ctrl.sv | 165 ++++++++++++++++
 tb/tb_spi_arbitro_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  spi_pkg
//  Shared encodings, mode constants and defaults for the SPI transaction
//  controller and its round-robin arbiter.
//  Revision: 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int SCK_DIV_DEF = 4;
    localparam int BITS_DEF    = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    // SPI modes as {CKP,CPH}
    typedef enum logic [1:0] {
        MODO0 = 2'b00,
        MODO1 = 2'b01,
        MODO2 = 2'b10,
        MODO3 = 2'b11
    } spi_mode_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [2:0] len;
    } xfer_cfg_t;

    function automatic xfer_cfg_t pick_cfg(
        input logic       sel,
        input logic [1:0] mode0,
        input logic [1:0] mode1,
        input logic [2:0] len0,
        input logic [2:0] len1
    );
        xfer_cfg_t cfg;
        cfg.mode = sel ? mode1 : mode0;
        cfg.len  = sel ? len1  : len0;
        return cfg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  rr_arb2
//  Two-input round-robin arbiter: combinational grant, last-served pointer
//  advanced on a completion strobe.
//  Revision: 1.0  initial release
// ============================================================================
module rr_arb2 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic       ADV,
    input  logic       ADV_ID,
    output logic [1:0] GNT,
    output logic       WIN_ID
);

    // Holds the requester served last; reset to 1 so requester 0 goes first.
    logic r_last;
    logic w_win;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_last <= 1'b1;
        end else if (ADV) begin
            r_last <= ADV_ID;
        end
    end

    always_comb begin
        w_win = 1'b0;
        case (REQ)
            2'b01:   w_win = 1'b0;
            2'b10:   w_win = 1'b1;
            2'b11:   w_win = ~r_last;
            default: w_win = 1'b0;
        endcase
    end

    assign WIN_ID = w_win;
    assign GNT    = (REQ == 2'b00) ? 2'b00 : (w_win ? 2'b10 : 2'b01);

endmodule
`default_nettype wire

// File: rtl/spi_arbitro_ctrl.sv
`default_nettype none
// ============================================================================
//  spi_arbitro_ctrl
//  Two-requester SPI transaction controller: arbitration, setup/hold guard
//  intervals around ENB, byte boundary marking and per-requester DONE.
//  Revision: 1.0  initial release
// ============================================================================
module spi_arbitro_ctrl
    import spi_pkg::*;
#(
    parameter int SCK_DIV   = SCK_DIV_DEF,
    parameter int BITS      = BITS_DEF,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic [1:0] MODE0,
    input  logic [1:0] MODE1,
    input  logic [2:0] LEN0,
    input  logic [2:0] LEN1,
    output logic [1:0] GNT,
    output logic [1:0] DONE,
    output logic       ENB,
    output logic       CKP,
    output logic       CPH,
    output logic       BYTE_START,
    output logic       BUSY
);

    localparam int c_BYTE_CYC = SCK_DIV * BITS;
    localparam int c_BCW      = (c_BYTE_CYC > 1) ? $clog2(c_BYTE_CYC) : 1;
    localparam int c_GMAX     = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int c_GCW      = $clog2(c_GMAX + 1);

    localparam logic [c_BCW-1:0] c_BIT_LAST   = c_BCW'(c_BYTE_CYC - 1);
    localparam logic [c_GCW-1:0] c_SETUP_LAST = c_GCW'(SETUP_CYC - 1);
    localparam logic [c_GCW-1:0] c_HOLD_LAST  = c_GCW'(HOLD_CYC - 1);
    localparam logic [c_GCW-1:0] c_HOLD_PRE   = c_GCW'((HOLD_CYC >= 2) ? HOLD_CYC - 2 : 0);

    logic [1:0]       r_state;
    logic [c_GCW-1:0] r_gcnt;
    logic [c_BCW-1:0] r_bcnt;
    logic [2:0]       r_byte;
    logic [2:0]       r_len;
    logic [1:0]       r_mode;
    logic [1:0]       r_gnt;
    logic [1:0]       r_done;
    logic             r_enb;
    logic             r_bs;
    logic             r_busy;
    logic             r_winner;

    logic [1:0]       w_gnt_nxt;
    logic             w_win_id;
    xfer_cfg_t        w_cfg;

    rr_arb2 u_arb (
        .CLK    (CLK),
        .RESET  (RESET),
        .REQ    (REQ),
        .ADV    (|r_done),
        .ADV_ID (r_winner),
        .GNT    (w_gnt_nxt),
        .WIN_ID (w_win_id)
    );

    assign w_cfg = pick_cfg(w_win_id, MODE0, MODE1, LEN0, LEN1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_gcnt   <= '0;
            r_bcnt   <= '0;
            r_byte   <= '0;
            r_len    <= '0;
            r_mode   <= MODO0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_enb    <= 1'b0;
            r_bs     <= 1'b0;
            r_busy   <= 1'b0;
            r_winner <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_enb  <= 1'b0;
                    r_bs   <= 1'b0;
                    r_done <= '0;
                    // Mode is only reloaded on a new grant so idle SCK level stays put
                    if (REQ != 2'b00) begin
                        r_state  <= ST_SETUP;
                        r_gnt    <= w_gnt_nxt;
                        r_winner <= w_win_id;
                        r_mode   <= w_cfg.mode;
                        r_len    <= w_cfg.len;
                        r_gcnt   <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                    end
                end

                ST_SETUP: begin
                    if (r_gcnt == c_SETUP_LAST) begin
                        r_state <= ST_ACTIVE;
                        r_enb   <= 1'b1;
                        r_bs    <= 1'b1;
                        r_bcnt  <= '0;
                        r_byte  <= '0;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end

                ST_ACTIVE: begin
                    if (r_bcnt == c_BIT_LAST) begin
                        if (r_byte == r_len) begin
                            r_state <= ST_HOLD;
                            r_enb   <= 1'b0;
                            r_bs    <= 1'b0;
                            r_gcnt  <= '0;
                            r_done  <= (HOLD_CYC == 1) ? r_gnt : 2'b00;
                        end else begin
                            r_bcnt <= '0;
                            r_byte <= r_byte + 1'b1;
                            r_bs   <= 1'b1;
                        end
                    end else begin
                        r_bcnt <= r_bcnt + 1'b1;
                        r_bs   <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (r_gcnt == c_HOLD_LAST) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_done  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                        r_done <= (r_gcnt == c_HOLD_PRE) ? r_gnt : 2'b00;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign GNT        = r_gnt;
    assign DONE       = r_done;
    assign ENB        = r_enb;
    assign CKP        = r_mode[1];
    assign CPH        = r_mode[0];
    assign BYTE_START = r_bs;
    assign BUSY       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbitro_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_spi_arbitro_ctrl
//  Directed and randomized checks of spi_arbitro_ctrl against a cycle-index
//  model derived from the timing rules.
//  Revision: 1.0  initial release
// ============================================================================
module tb_spi_arbitro_ctrl;

    localparam int S = 2;
    localparam int H = 2;
    localparam int P = 32;   // SCK_DIV * BITS

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [1:0] REQ = 2'b00;
    logic [1:0] MODE0 = 2'b00;
    logic [1:0] MODE1 = 2'b00;
    logic [2:0] LEN0 = 3'd0;
    logic [2:0] LEN1 = 3'd0;
    logic [1:0] GNT;
    logic [1:0] DONE;
    logic       ENB, CKP, CPH, BYTE_START, BUSY;

    int checks = 0;
    int failures = 0;
    int last_served = 1;
    logic [1:0] mode_held = 2'b00;

    spi_arbitro_ctrl #(
        .SCK_DIV   (4),
        .BITS      (8),
        .SETUP_CYC (S),
        .HOLD_CYC  (H)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .MODE0      (MODE0),
        .MODE1      (MODE1),
        .LEN0       (LEN0),
        .LEN1       (LEN1),
        .GNT        (GNT),
        .DONE       (DONE),
        .ENB        (ENB),
        .CKP        (CKP),
        .CPH        (CPH),
        .BYTE_START (BYTE_START),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector {GNT,DONE,ENB,BYTE_START,BUSY,CKP,CPH}
    function automatic logic [15:0] outv();
        return {7'd0, GNT, DONE, ENB, BYTE_START, BUSY, CKP, CPH};
    endfunction

    function automatic logic [15:0] mkv(input logic [1:0] g, input logic [1:0] d, input logic e,
                                        input logic b, input logic bz, input logic [1:0] m);
        return {7'd0, g, d, e, b, bz, m};
    endfunction

    function automatic int exp_winner(input logic [1:0] req, input int last);
        if (req == 2'b11) return (last == 0) ? 1 : 0;
        return req[1] ? 1 : 0;
    endfunction

    // kind: 0 plain, 1 drop REQ at cycle 10, 2 change MODE0 at cycle 0, 3 scramble inputs
    task automatic txn(input logic [1:0] req, input logic [1:0] m0, input logic [1:0] m1,
                       input logic [2:0] l0, input logic [2:0] l1, input int kind);
        int w, n, total, enb_cnt, last_c;
        logic [1:0] mode, oh, d;
        logic e, b;
        REQ = req; MODE0 = m0; MODE1 = m1; LEN0 = l0; LEN1 = l1;
        w = exp_winner(req, last_served);
        mode = (w == 1) ? m1 : m0;
        n = ((w == 1) ? int'(l1) : int'(l0)) + 1;
        oh = (w == 1) ? 2'b10 : 2'b01;
        total = S + n * P + H;
        last_c = total - 1;
        enb_cnt = 0;
        for (int c = 0; c < total; c++) begin
            tick();
            e = (c >= S) && (c < S + n * P);
            b = e && (((c - S) % P) == 0);
            d = (c == last_c) ? oh : 2'b00;
            chk($sformatf("txn w=%0d n=%0d cyc=%0d", w, n, c), outv(), mkv(oh, d, e, b, 1'b1, mode));
            if (ENB) enb_cnt++;
            if (kind == 1 && c == 10) REQ = 2'b00;
            if (kind == 2 && c == 0) MODE0 = 2'b10;
            if (kind == 3) begin
                REQ = 2'($urandom); MODE0 = 2'($urandom); MODE1 = 2'($urandom);
                LEN0 = 3'($urandom); LEN1 = 3'($urandom);
            end
        end
        chk($sformatf("enb_len w=%0d", w), 16'(enb_cnt), 16'(n * P));
        REQ = 2'b00;
        tick();
        chk($sformatf("post_idle w=%0d", w), outv(), mkv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, mode));
        last_served = w;
        mode_held = mode;
    endtask

    task automatic idle(input int k);
        REQ = 2'b00;
        for (int i = 0; i < k; i++) begin
            tick();
            chk($sformatf("idle %0d", i), outv(), mkv(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, mode_held));
        end
    endtask

    initial begin
        // Reset dominates an active request
        RESET = 1'b1; REQ = 2'b11;
        tick(); tick(); tick();
        chk("reset_vals", outv(), 16'd0);
        RESET = 1'b0; REQ = 2'b00;
        tick();
        chk("after_reset", outv(), 16'd0);

        txn(2'b01, 2'b01, 2'b00, 3'd0, 3'd0, 0);
        txn(2'b10, 2'b00, 2'b11, 3'd0, 3'd2, 0);
        idle(4);

        // Continuous dual request alternates 01,10,01
        txn(2'b11, 2'b00, 2'b01, 3'd0, 3'd0, 0);
        txn(2'b11, 2'b00, 2'b01, 3'd0, 3'd0, 0);
        txn(2'b11, 2'b00, 2'b01, 3'd0, 3'd0, 0);
        idle(2);

        txn(2'b01, 2'b10, 2'b00, 3'd1, 3'd0, 1);
        idle(1);

        // Reset in the middle of ACTIVE, after requester 0 was served last
        REQ = 2'b01; MODE0 = 2'b11; LEN0 = 3'd3;
        tick();
        chk("rst_mid_gnt", 16'(GNT), 16'(2'b01));
        for (int c = 1; c <= S + 20; c++) tick();
        chk("rst_mid_enb", 16'(ENB), 16'd1);
        RESET = 1'b1; REQ = 2'b00;
        tick();
        chk("rst_mid_out", outv(), 16'd0);
        RESET = 1'b0;
        tick();
        chk("rst_mid_nodone", outv(), 16'd0);
        last_served = 1;
        mode_held = 2'b00;
        txn(2'b11, 2'b01, 2'b10, 3'd0, 3'd0, 0);

        txn(2'b01, 2'b00, 2'b11, 3'd0, 3'd0, 2);

        for (int i = 0; i < 24; i++) begin
            logic [1:0] rq;
            rq = 2'($urandom_range(1, 3));
            txn(rq, 2'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                ($urandom_range(0, 1) == 1) ? 3 : 0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
